// File: rtl/fwd_hazard_pkg.sv
// rtl/fwd_hazard_pkg.sv - shared select encodings and scoreboard entry type for fwd_hazard_ctrl
package fwd_hazard_pkg;

   localparam int ENT_DST_W  = 8;
   localparam int ENT_CNT_W  = 8;
   localparam int FWD_SEL_RF = 0;

   typedef struct packed {
      logic                 valid;
      logic [ENT_DST_W-1:0] dst;
      logic [ENT_CNT_W-1:0] cnt;
   } fwd_entry_t;

   function automatic int sel_w(input int num_fwd);
      return $clog2(num_fwd + 2);
   endfunction

   function automatic int fwd_sel_long(input int num_fwd);
      return num_fwd + 1;
   endfunction

endpackage

// File: rtl/fwd_pend_entry.sv
// rtl/fwd_pend_entry.sv - one long-latency scoreboard entry with countdown and address match
module fwd_pend_entry
   import fwd_hazard_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int NUM_SRC  = 2,
   parameter int LONG_LAT = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      alloc_i,
   input  logic [ADDR_W-1:0]         alloc_dst_i,
   input  logic [NUM_SRC*ADDR_W-1:0] src_addr_i,
   input  logic [ADDR_W-1:0]         iss_dst_i,
   output logic                      valid_o,
   output logic                      retire_o,
   output logic [ADDR_W-1:0]         dst_o,
   output logic [NUM_SRC-1:0]        eq_any_o,
   output logic [NUM_SRC-1:0]        eq_ready_o,
   output logic                      iss_eq_o
);

   fwd_entry_t ent_q, ent_d;

   always_comb begin
      ent_d = ent_q;
      if (alloc_i) begin
         ent_d.valid = 1'b1;
         ent_d.dst   = ENT_DST_W'(alloc_dst_i);
         ent_d.cnt   = ENT_CNT_W'(LONG_LAT);
      end else if (ent_q.valid) begin
         if (ent_q.cnt == ENT_CNT_W'(1)) begin
            ent_d = '0;
         end else begin
            ent_d.cnt = ent_q.cnt - ENT_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ent_q <= '0;
      end else begin
         ent_q <= ent_d;
      end
   end

   assign valid_o  = ent_q.valid;
   assign retire_o = ent_q.valid && (ent_q.cnt == ENT_CNT_W'(1));
   assign dst_o    = ent_q.dst[ADDR_W-1:0];
   assign iss_eq_o = ent_q.valid && (ent_q.dst == ENT_DST_W'(iss_dst_i));

   always_comb begin
      logic hit;
      hit        = 1'b0;
      eq_any_o   = '0;
      eq_ready_o = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         hit           = ent_q.valid && (ent_q.dst == ENT_DST_W'(src_addr_i[i*ADDR_W +: ADDR_W]));
         eq_any_o[i]   = hit;
         eq_ready_o[i] = hit && retire_o;
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX operand forwarding selects, load-use and long-op scoreboard stalls
// Optional FWD_HAZARD_STATS_EN adds saturating stall/WAW cycle counters.
module fwd_hazard_ctrl
   import fwd_hazard_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int NUM_SRC  = 2,
   parameter int NUM_FWD  = 2,
   parameter int LONG_LAT = 4,
   parameter int MAX_PEND = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_SRC-1:0]                 src_valid,
   input  logic [NUM_SRC*ADDR_W-1:0]          src_addr,
   input  logic [NUM_FWD-1:0]                 fwd_we,
   input  logic [NUM_FWD*ADDR_W-1:0]          fwd_addr,
   input  logic [NUM_FWD-1:0]                 fwd_is_load,
   input  logic                               iss_valid,
   input  logic                               iss_we,
   input  logic                               iss_long,
   input  logic [ADDR_W-1:0]                  iss_dst,
   output logic [NUM_SRC*sel_w(NUM_FWD)-1:0]  fwd_sel,
   output logic                               stall,
   output logic                               long_wb_valid,
   output logic [ADDR_W-1:0]                  long_wb_addr,
   output logic                               pend_full,
`ifdef FWD_HAZARD_STATS_EN
   output logic [$clog2(MAX_PEND+1)-1:0]      pend_count,
   output logic [31:0]                        stat_stall_cycles,
   output logic [31:0]                        stat_waw_stalls
`else
   output logic [$clog2(MAX_PEND+1)-1:0]      pend_count
`endif
);

   localparam int SEL_W = sel_w(NUM_FWD);
   localparam int CNT_W = $clog2(MAX_PEND + 1);
   localparam logic [SEL_W-1:0] SEL_RF   = SEL_W'(FWD_SEL_RF);
   localparam logic [SEL_W-1:0] SEL_LONG = SEL_W'(fwd_sel_long(NUM_FWD));

   if (LONG_LAT <= NUM_FWD) begin : g_bad_lat
      $error("fwd_hazard_ctrl: LONG_LAT must exceed NUM_FWD");
   end
   if (LONG_LAT > 255 || ADDR_W > ENT_DST_W) begin : g_bad_width
      $error("fwd_hazard_ctrl: LONG_LAT or ADDR_W exceeds scoreboard field width");
   end
   if (MAX_PEND < 1 || MAX_PEND > 8) begin : g_bad_pend
      $error("fwd_hazard_ctrl: MAX_PEND must be 1..8");
   end

   logic [MAX_PEND-1:0]               ent_valid, ent_retire, ent_iss_eq, ent_alloc;
   logic [MAX_PEND-1:0][NUM_SRC-1:0]  ent_eq_any, ent_eq_ready;
   logic [MAX_PEND-1:0][ADDR_W-1:0]   ent_dst;

   logic [NUM_SRC-1:0][SEL_W-1:0]     sel_raw;
   logic [NUM_SRC-1:0]                src_live, src_wait;
   logic                              load_use, raw_haz, waw_haz, struct_haz, stall_raw;
   logic                              alloc_ok, full_raw, wb_valid_raw;
   logic [ADDR_W-1:0]                 wb_addr_raw;
   logic [CNT_W-1:0]                  count_raw;
   logic                              unused_load_hi;

   // Only stage 0 load data is unavailable; older stages can always forward.
   assign unused_load_hi = ^fwd_is_load;

   for (genvar e = 0; e < MAX_PEND; e++) begin : g_ent
      fwd_pend_entry #(
         .ADDR_W   (ADDR_W),
         .NUM_SRC  (NUM_SRC),
         .LONG_LAT (LONG_LAT)
      ) u_ent (
         .clk         (clk),
         .reset       (reset),
         .alloc_i     (ent_alloc[e]),
         .alloc_dst_i (iss_dst),
         .src_addr_i  (src_addr),
         .iss_dst_i   (iss_dst),
         .valid_o     (ent_valid[e]),
         .retire_o    (ent_retire[e]),
         .dst_o       (ent_dst[e]),
         .eq_any_o    (ent_eq_any[e]),
         .eq_ready_o  (ent_eq_ready[e]),
         .iss_eq_o    (ent_iss_eq[e])
      );
   end

   always_comb begin
      logic [ADDR_W-1:0] a;
      logic              rdy, wt;
      a        = '0;
      rdy      = 1'b0;
      wt       = 1'b0;
      sel_raw  = '0;
      src_live = '0;
      src_wait = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         a   = src_addr[i*ADDR_W +: ADDR_W];
         rdy = 1'b0;
         wt  = 1'b0;
         for (int e = 0; e < MAX_PEND; e++) begin
            rdy = rdy | ent_eq_ready[e][i];
            wt  = wt | (ent_eq_any[e][i] & ~ent_retire[e]);
         end
         src_live[i] = src_valid[i] && (a != '0);
         src_wait[i] = wt;
         sel_raw[i]  = SEL_RF;
         if (src_live[i]) begin
            if (rdy) begin
               sel_raw[i] = SEL_LONG;
            end else begin
               // Descending scan so the youngest matching stage wins.
               for (int k = NUM_FWD - 1; k >= 0; k--) begin
                  if (fwd_we[k] && (fwd_addr[k*ADDR_W +: ADDR_W] == a)) begin
                     sel_raw[i] = SEL_W'(k + 1);
                  end
               end
            end
         end
      end
   end

   always_comb begin
      count_raw = '0;
      for (int e = 0; e < MAX_PEND; e++) begin
         count_raw = count_raw + CNT_W'(ent_valid[e]);
      end
      full_raw = (count_raw == CNT_W'(MAX_PEND));
   end

   always_comb begin
      load_use = 1'b0;
      raw_haz  = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (src_live[i] && (sel_raw[i] == SEL_W'(1)) && fwd_is_load[0]) load_use = 1'b1;
         if (src_live[i] && src_wait[i]) raw_haz = 1'b1;
      end
      waw_haz    = iss_valid && iss_we && (iss_dst != '0) && (|ent_iss_eq);
      struct_haz = iss_valid && iss_long && full_raw;
      stall_raw  = load_use || raw_haz || waw_haz || struct_haz;
   end

   always_comb begin
      logic taken;
      taken     = 1'b0;
      alloc_ok  = iss_valid && iss_long && iss_we && (iss_dst != '0) && !stall_raw;
      ent_alloc = '0;
      for (int e = 0; e < MAX_PEND; e++) begin
         if (!taken && !ent_valid[e]) begin
            ent_alloc[e] = alloc_ok;
            taken        = 1'b1;
         end
      end
   end

   always_comb begin
      wb_valid_raw = |ent_retire;
      wb_addr_raw  = '0;
      for (int e = 0; e < MAX_PEND; e++) begin
         if (ent_retire[e]) wb_addr_raw = wb_addr_raw | ent_dst[e];
      end
   end

   // Outputs are held at zero for the whole reset window, combinational ones included.
   assign fwd_sel       = reset ? sel_raw : '0;
   assign stall         = reset && stall_raw;
   assign long_wb_valid = reset && wb_valid_raw;
   assign long_wb_addr  = reset ? wb_addr_raw : '0;
   assign pend_full     = reset && full_raw;
   assign pend_count    = reset ? count_raw : '0;

`ifdef FWD_HAZARD_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, waw_cnt_q, waw_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      waw_cnt_d   = waw_cnt_q;
      if (stall_raw && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (waw_haz && (waw_cnt_q != '1))     waw_cnt_d   = waw_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         waw_cnt_q   <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         waw_cnt_q   <= waw_cnt_d;
      end
   end

   assign stat_stall_cycles = stall_cnt_q;
   assign stat_waw_stalls   = waw_cnt_q;
`endif

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Parametrised successor to the EX-stage forwarding control. It generates per-source forwarding selects for NUM_SRC operands across NUM_FWD producer stages and detects load-use hazards. It also keeps a small scoreboard of in-flight long-latency (mult/div) writes and uses it to stall on RAW, WAW and structural hazards. It sits between ID/EX and the EX operand muxes; its stall output feeds the PC/IF/ID hold logic.

Parameters:
ADDR_W, 5, register address width
NUM_SRC, 2, operand read ports checked per cycle
NUM_FWD, 2, forwarding producer stages; index 0 is the youngest (EX/MEM)
LONG_LAT, 4, cycles from long-op issue to result valid; elaboration error unless LONG_LAT > NUM_FWD
MAX_PEND, 2, scoreboard entries (1..8)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
src_valid  in  NUM_SRC  operand i is read this cycle
src_addr  in  NUM_SRC*ADDR_W  operand addresses, packed, i at [i*ADDR_W +: ADDR_W]
fwd_we  in  NUM_FWD  stage k will write the register file
fwd_addr  in  NUM_FWD*ADDR_W  stage k destination
fwd_is_load  in  NUM_FWD  stage k data comes from memory (not yet available in stage 0)
iss_valid  in  1  instruction in ID/EX attempting to issue
iss_we  in  1  issuing instruction writes a register
iss_long  in  1  issuing instruction is a long-latency op
iss_dst  in  ADDR_W  issuing destination
fwd_sel  out  NUM_SRC*SEL_W  per-operand select; SEL_W = clog2(NUM_FWD+2)
stall  out  1  hold ID/EX and earlier stages this cycle
long_wb_valid  out  1  long result is written back this cycle
long_wb_addr  out  ADDR_W  its destination
pend_full  out  1  all scoreboard entries valid
pend_count  out  clog2(MAX_PEND+1)  valid entries

Behaviour:
- fwd_sel encoding: 0 = register file; k+1 = producer stage k; NUM_FWD+1 = long-unit result.
- Per-operand select, combinational. Priority order:
  - src_valid=0 or addr==0 -> 0.
  - Valid scoreboard entry with dst==addr and cnt==1 -> NUM_FWD+1.
  - Otherwise, lowest k with fwd_we[k] and fwd_addr[k]==addr -> k+1.
  - Otherwise 0.
- Scoreboard entry: {valid, dst, cnt}.
  - Every cycle, each valid entry decrements cnt.
  - An entry with cnt==1 drives long_wb_valid=1 and long_wb_addr=dst, then clears at the next edge.
  - At most one entry has cnt==1 in a cycle, because allocations are at least one cycle apart.
- stall = OR of:
  - load-use: any valid operand whose selected stage is 0 with fwd_is_load[0].
  - RAW: any valid operand matching a valid entry with cnt>1 (addr!=0).
  - WAW: iss_valid & iss_we & iss_dst!=0 & iss_dst matches any valid entry.
  - structural: iss_valid & iss_long & pend_full. No same-cycle reuse of an entry that is retiring.
- Allocation:
  - Condition: iss_valid & iss_long & iss_we & iss_dst!=0 & !stall.
  - Takes the lowest free entry: valid<=1, dst<=iss_dst, cnt<=LONG_LAT.
  - Visible to the checks from the next cycle.
- A stall never cancels in-flight entries; they keep counting.
- Reset (reset==0): all entries cleared, counters 0.
  - While reset is low, all outputs are forced to 0 regardless of inputs; this includes the combinational outputs.
  - Mid-operation reset discards pending entries. Their writebacks never appear.
- pend_count and pend_full are registered-state derived and do not reflect this cycle's allocation.

Optional Feature:
FWD_HAZARD_STATS_EN.
- Defined: adds outputs stat_stall_cycles (32) and stat_waw_stalls (32).
  - stat_stall_cycles increments every cycle stall=1.
  - stat_waw_stalls increments every cycle the WAW term is true.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fwd_hazard_pkg: SEL_W function, FWD_SEL_RF=0, FWD_SEL_LONG function of NUM_FWD, entry struct typedef {valid, dst, cnt}.
- One sub-module: fwd_pend_entry (single scoreboard entry with countdown, alloc/retire, match outputs eq_any and eq_ready). It is instantiated MAX_PEND times with a generate loop.

Test Plan:
- fwd_we=2'b11, fwd_addr both 5, src0=5 -> fwd_sel0=1 (youngest wins); fwd_we=2'b10 -> 2; addr 0 -> 0, no stall.
- fwd_is_load[0]=1, fwd_addr[0]=8, src1=8 -> stall=1; the next cycle, with the load in stage 1 and not in stage 0 -> stall=0, sel1=2.
- Long issue dst=9 at t0 (LONG_LAT=4), then src0=9 from t1 -> stall high for t1..t3; at t3+1 entry cnt==1 -> stall=0, sel0=3, long_wb_valid=1, addr=9; the following cycle pend_count=0.
- MAX_PEND=2, two long issues (dst 3, 4) in back-to-back cycles, third long issue -> stall=1 (pend_full) until the first retires; short issue with iss_dst=4 while pending -> WAW stall.
- Assert reset low with 2 entries pending -> all outputs 0 immediately; after release, pend_count=0 and no long_wb_valid ever appears for them.
- With FWD_HAZARD_STATS_EN: 5 stall cycles, 2 of them WAW -> stat_stall_cycles=5, stat_waw_stalls=2.
